// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad scan, debounce and two-digit history.
// Define KEYPAD_SYNC_EN to insert the 2-flop row synchronizer.
module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 4800,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SET_END = SW'(SETTLE_CYCLES);
  localparam logic [DW-1:0] DB_END  = DW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    SCAN, DEBOUNCE, HELD, RELEASE
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      col, row, low_idx;
  logic [SW-1:0]   set_cnt;
  logic [DW-1:0]   db_cnt, db_next;
  logic [3:0]      rows_s, key_hex;
  logic            settle_done, any_low;
  logic            key_dn, db_full;
  logic            col_adv, fire;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] rows_m, rows_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_m <= '1;
      rows_q <= '1;
    end else begin
      rows_m <= rows;
      rows_q <= rows_m;
    end
  end

  assign rows_s = rows_q;
`else
  assign rows_s = rows;
`endif

  assign settle_done = (state == SCAN) && (set_cnt == SET_END);
  assign any_low     = ~&rows_s;
  assign key_dn      = ~rows_s[row];
  assign db_next     = db_cnt + DW'(1);
  assign db_full     = (db_next == DB_END);

  // Lowest-index low row wins when several are down.
  always_comb begin
    low_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_s[i]) low_idx = 2'(i);
    end
  end

  always_comb begin
    key_hex = 4'h0;
    unique case ({row, col})
      4'b00_00: key_hex = 4'h1;
      4'b00_01: key_hex = 4'h2;
      4'b00_10: key_hex = 4'h3;
      4'b00_11: key_hex = 4'hA;
      4'b01_00: key_hex = 4'h4;
      4'b01_01: key_hex = 4'h5;
      4'b01_10: key_hex = 4'h6;
      4'b01_11: key_hex = 4'hB;
      4'b10_00: key_hex = 4'h7;
      4'b10_01: key_hex = 4'h8;
      4'b10_10: key_hex = 4'h9;
      4'b10_11: key_hex = 4'hC;
      4'b11_00: key_hex = 4'hE;
      4'b11_01: key_hex = 4'h0;
      4'b11_10: key_hex = 4'hF;
      4'b11_11: key_hex = 4'hD;
      default:  key_hex = 4'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SCAN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SCAN:
        if (settle_done && any_low) state_nxt = DEBOUNCE;
      DEBOUNCE:
        if (!key_dn)      state_nxt = SCAN;
        else if (db_full) state_nxt = HELD;
      HELD:
        if (!key_dn) state_nxt = RELEASE;
      RELEASE:
        if (key_dn)       state_nxt = HELD;
        else if (db_full) state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  always_comb begin
    col_adv = 1'b0;
    fire    = 1'b0;
    unique case (state)
      SCAN:     col_adv = settle_done && !any_low;
      DEBOUNCE: begin
        col_adv = !key_dn;
        fire    = key_dn && db_full;
      end
      HELD:     col_adv = 1'b0;
      RELEASE:  col_adv = !key_dn && db_full;
      default:  col_adv = 1'b0;
    endcase
  end

  assign cols = ~(4'b0001 << col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      set_cnt   <= '0;
      db_cnt    <= '0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= fire;
      if (col_adv) col <= col + 2'd1;
      if (state == SCAN && !settle_done) set_cnt <= set_cnt + SW'(1);
      else                               set_cnt <= '0;
      if (settle_done && any_low) row <= low_idx;
      unique case (state)
        DEBOUNCE: db_cnt <= db_next;
        RELEASE:  db_cnt <= key_dn ? '0 : db_next;
        default:  db_cnt <= '0;
      endcase
      if (fire) begin
        digit_old <= digit_new;
        digit_new <= key_hex;
      end
    end
  end

endmodule
